// File: rtl/mem_if.sv
// Bus between the test program and the memory block. The test program drives
// strobes, address and write data through the test modport; the memory samples
// them and returns read data through the mem modport.
interface mem_if #(
  parameter int ADDR_W = 5,
  parameter int WIDTH  = 8
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data_out;

  modport test (
    output read, write, addr, data_in,
    input  data_out
  );

  modport mem (
    input  read, write, addr, data_in,
    output data_out
  );
endinterface

// File: rtl/sync_mem_core.sv
// Single-port synchronous memory, DEPTH x WIDTH, registered read data.
// A read and a write on the same edge return the old word (read-before-write).
// Addresses at or above DEPTH are ignored on write and read back as zero.
module sync_mem_core #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  mem_if.mem   bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             in_range;
  logic [WIDTH-1:0] rd_word;

  // With a power-of-2 depth every address is valid, so skip the compare.
  generate
    if (DEPTH == (2 ** ADDR_W)) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_partial
      localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
      assign in_range = ({1'b0, bus.addr} < DEPTH_W);
    end
  endgenerate

  assign rd_word = in_range ? mem[bus.addr] : '0;

  // Storage array: cleared by reset, written only for in-range addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.write && in_range) begin
      mem[bus.addr] <= bus.data_in;
    end
  end

  // Read data register: samples the pre-write word, holds when read is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out <= '0;
    end else if (bus.read) begin
      bus.data_out <= rd_word;
    end
  end
endmodule

// File: tb/tb_sync_mem_core.sv
// Bench for sync_mem_core: a 32-word instance and a 24-word instance share the
// clock and reset. Reads push the expected word onto a per-instance queue when
// issued; the queue is popped and compared one cycle later.
module tb_sync_mem_core;
  logic clk;
  logic rst_n;

  mem_if #(.ADDR_W(5), .WIDTH(8)) if32 ();
  mem_if #(.ADDR_W(5), .WIDTH(8)) if24 ();

  sync_mem_core #(.DEPTH(32), .WIDTH(8)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if32)
  );

  sync_mem_core #(.DEPTH(24), .WIDTH(8)) dut24 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if24)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model32 [32];
  logic [7:0] model24 [24];
  logic [7:0] sb32 [$];
  logic [7:0] sb24 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_models();
    for (int i = 0; i < 32; i++) model32[i] = 8'h00;
    for (int i = 0; i < 24; i++) model24[i] = 8'h00;
  endtask

  task automatic idle_bus();
    if32.read = 1'b0; if32.write = 1'b0; if32.addr = '0; if32.data_in = '0;
    if24.read = 1'b0; if24.write = 1'b0; if24.addr = '0; if24.data_in = '0;
  endtask

  // One access on the 32-word instance; inputs driven #1 after an edge.
  task automatic acc32(input logic rd, input logic wr, input int a,
                       input logic [7:0] d, input string nm);
    logic [7:0] exp_v;
    logic [7:0] got_v;
    if32.read = rd; if32.write = wr; if32.addr = 5'(a); if32.data_in = d;
    if (rd) sb32.push_back(model32[a]);
    if (wr) model32[a] = d;
    @(posedge clk); #1;
    if32.read = 1'b0; if32.write = 1'b0;
    if (rd) begin
      exp_v = sb32.pop_front();
      got_v = if32.data_out;
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s addr=%0d got=%h expected=%h", nm, a, got_v, exp_v);
      end
    end
  endtask

  task automatic acc24(input logic rd, input logic wr, input int a,
                       input logic [7:0] d, input string nm);
    logic [7:0] exp_v;
    logic [7:0] got_v;
    if24.read = rd; if24.write = wr; if24.addr = 5'(a); if24.data_in = d;
    if (rd) sb24.push_back((a < 24) ? model24[a] : 8'h00);
    if (wr && a < 24) model24[a] = d;
    @(posedge clk); #1;
    if24.read = 1'b0; if24.write = 1'b0;
    if (rd) begin
      exp_v = sb24.pop_front();
      got_v = if24.data_out;
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s addr=%0d got=%h expected=%h", nm, a, got_v, exp_v);
      end
    end
  endtask

  task automatic check_out(input string nm, input logic [7:0] exp32, input logic [7:0] exp24);
    n_tests++;
    if (if32.data_out !== exp32) begin
      n_fail++;
      $display("FAIL %s (depth32) got=%h expected=%h", nm, if32.data_out, exp32);
    end
    n_tests++;
    if (if24.data_out !== exp24) begin
      n_fail++;
      $display("FAIL %s (depth24) got=%h expected=%h", nm, if24.data_out, exp24);
    end
  endtask

  task automatic test_reset();
    idle_bus();
    clear_models();
    rst_n = 1'b0;
    // Strobes active during reset must not touch memory.
    if32.write = 1'b1; if32.read = 1'b1; if32.data_in = 8'hEE;
    if24.write = 1'b1; if24.read = 1'b1; if24.data_in = 8'hEE;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_data_out", 8'h00, 8'h00);
    idle_bus();
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) acc32(1'b1, 1'b0, k, 8'h00, "reset_read");
    acc24(1'b1, 1'b0, 0, 8'h00, "reset_read24");
  endtask

  task automatic test_write_read();
    for (int k = 0; k < 32; k++) acc32(1'b0, 1'b1, k, 8'(k), "wr_k");
    for (int k = 0; k < 32; k++) acc32(1'b1, 1'b0, k, 8'h00, "rd_k");
    for (int k = 0; k < 24; k++) acc24(1'b0, 1'b1, k, 8'(k + 8'h40), "wr24_k");
    for (int k = 23; k >= 0; k--) acc24(1'b1, 1'b0, k, 8'h00, "rd24_k");
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 32; k++) acc32(1'b0, 1'b1, k, 8'hFF, "wr_ff");
    acc32(1'b1, 1'b0, 9, 8'h00, "rd_ff");
    // Pulse reset between edges: data_out must clear without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    check_out("async_reset_immediate", 8'h00, 8'h00);
    rst_n = 1'b1;
    clear_models();
    for (int k = 0; k < 32; k += 5) acc32(1'b1, 1'b0, k, 8'h00, "rd_after_rst");
    acc32(1'b1, 1'b0, 31, 8'h00, "rd_after_rst");
    acc24(1'b1, 1'b0, 23, 8'h00, "rd24_after_rst");
  endtask

  task automatic test_rd_wr_same_edge();
    acc32(1'b0, 1'b1, 3, 8'hA5, "rw_setup");
    acc32(1'b1, 1'b1, 3, 8'h5A, "rw_old_data");
    acc32(1'b1, 1'b0, 3, 8'h00, "rw_new_data");
  endtask

  task automatic test_hold();
    acc32(1'b0, 1'b1, 7, 8'h07, "hold_setup");
    acc32(1'b1, 1'b0, 7, 8'h00, "hold_read");
    for (int c = 0; c < 3; c++) begin
      if32.addr = 5'(c + 12);
      @(posedge clk); #1;
      n_tests++;
      if (if32.data_out !== 8'h07) begin
        n_fail++;
        $display("FAIL hold cycle=%0d got=%h expected=07", c, if32.data_out);
      end
    end
  endtask

  task automatic test_out_of_range();
    // Fill the words a truncated or wrapped address would alias onto.
    acc24(1'b0, 1'b1, 6, 8'h33, "oor_setup6");
    acc24(1'b0, 1'b1, 14, 8'h44, "oor_setup14");
    acc24(1'b0, 1'b1, 30, 8'h11, "oor_write");
    acc24(1'b1, 1'b0, 30, 8'h00, "oor_read30");
    acc24(1'b1, 1'b0, 6, 8'h00, "oor_alias6");
    acc24(1'b1, 1'b0, 14, 8'h00, "oor_alias14");
    acc24(1'b1, 1'b0, 23, 8'h00, "oor_last_valid");
    acc24(1'b1, 1'b1, 24, 8'h55, "oor_rw24");
    acc24(1'b1, 1'b0, 0, 8'h00, "oor_alias0");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) begin
      acc32(1'b1, 1'b1, k, 8'($urandom_range(0, 255)), "b2b_rw");
    end
    for (int k = 0; k < 16; k++) acc32(1'b1, 1'b0, k, 8'h00, "b2b_rd");
  endtask

  initial begin
    rst_n = 1'b0;
    idle_bus();
    test_reset();
    test_write_read();
    test_async_reset();
    test_rd_wr_same_edge();
    test_hold();
    test_out_of_range();
    test_back_to_back();
    if (sb32.size() != 0 || sb24.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain left32=%0d left24=%0d expected=0",
               sb32.size(), sb24.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
